edge_event_arbiter: RTL and testbench
=====================================

Name: edge_event_arbiter

Overview:
- Multi-channel input event controller for front-panel, joystick and mouse style inputs.
- Synchronises and debounces CHANNELS asynchronous level inputs, then detects rising and falling edges per channel.
- Latches enabled edges as pending requests and arbitrates them round-robin into a small event FIFO.
- The CPU-side port logic reads the FIFO through a valid/ready pop interface; it also sees an interrupt and a sticky overflow flag.

Parameters:
- CHANNELS, 8, number of input channels (1..16).
- DEBOUNCE, 16, consecutive ce ticks an input must hold a new level before it is accepted (>=1).
- FIFO_DEPTH, 8, event FIFO entries (power of two, >=2).
- IDLE_LEVEL, {CHANNELS{1'b0}}, reset value of each channel's debounced level.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  debounce tick enable; sync, arbiter and FIFO run every clock.
- signal_in  in  CHANNELS  raw asynchronous inputs.
- rise_en  in  CHANNELS  per-channel enable for rising-edge events.
- fall_en  in  CHANNELS  per-channel enable for falling-edge events.
- level_out  out  CHANNELS  debounced levels.
- evt_valid  out  1  FIFO head is valid.
- evt_chan  out  $clog2(CHANNELS) (min 1)  channel of head event.
- evt_dir  out  1  head direction: 1=rise, 0=fall.
- evt_ready  in  1  pop head when evt_valid & evt_ready.
- evt_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: an event was lost.
- overflow_clr  in  1  clears overflow.
- irq  out  1  evt_valid | overflow, registered.

Behaviour:
- Reset (async assert, sync-release-safe):
  - sync flops = IDLE_LEVEL; level_out = IDLE_LEVEL; debounce counters = 0.
  - pending bits = 0; RR pointer = 0; FIFO empty.
  - evt_valid = 0, evt_chan = 0, evt_dir = 0, evt_count = 0, overflow = 0, irq = 0.
  - Reset mid-operation discards all pending and queued events.
- Sync: two flops per channel, giving s[i].
- Debounce, per channel:
  - If s[i]==level_out[i], counter = 0.
  - Else, on a ce tick, counter increments.
  - When the counter is at DEBOUNCE-1 on a ce tick: level_out[i] <= s[i], counter <= 0.
  - A glitch shorter than DEBOUNCE ce ticks resets the counter and produces no event.
- Edge: the same clock that updates level_out[i] to 1 (or 0) raises rise_req[i] (or fall_req[i]), if rise_en[i] (or fall_en[i]) is high at that clock.
- Pending: 2*CHANNELS bits, index 2*i+0 = rise, 2*i+1 = fall.
  - A req sets its bit.
  - A bit clears when granted.
  - Set and grant of the same bit in the same clock: the bit stays set and no overflow is flagged.
  - Req arriving while the bit is already set and not granted that clock: the event is coalesced and overflow <= 1.
  - Clearing an enable does not clear bits that are already pending.
- Arbiter:
  - Each clock where the FIFO is not full (count < FIFO_DEPTH at clock start, no bypass), grant the first set pending bit at or after ptr, searching cyclically.
  - Push {i, dir}; ptr <= granted index + 1 (mod 2*CHANNELS).
  - When the FIFO is full, no grant is made and pending bits hold; no loss occurs.
- FIFO:
  - First-word-fall-through; evt_chan and evt_dir are valid whenever evt_valid is high.
  - Pop on evt_valid & evt_ready.
  - Push and pop in the same clock leave the count unchanged.
  - Pop while empty is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Latency: with ce=1 and no contention, evt_valid rises DEBOUNCE+3 clock edges after the first edge that samples the new signal_in level.
- overflow: set by coalescing; overflow_clr clears it. A set in the same clock as a clear wins (overflow stays 1).
- irq: registered one clock after evt_valid | overflow.

Test Plan:
- Reset: hold reset_n=0 with IDLE_LEVEL=8'h01 -> level_out=8'h01, all other outputs 0; release with signal_in=8'h01 -> no events.
- Single edge: DEBOUNCE=4, ce=1, rise_en=8'hFF, set signal_in[3]=1 -> evt_valid after 7 edges, evt_chan=3, evt_dir=1, evt_count=1; pop -> evt_count=0.
- Glitch and debounce: pulse signal_in[2] high for 3 ce ticks with DEBOUNCE=4 -> no event. With ce every 4th clock, a 16-clock-stable level -> exactly one event.
- Round-robin: channels 1, 5, 6 rise in the same clock, ptr=0 -> FIFO order (1,rise),(5,rise),(6,rise); next simultaneous batch continues searching from index 13.
- Full FIFO: FIFO_DEPTH=8, evt_ready=0, 10 distinct events -> evt_count=8, 2 bits remain pending, overflow=0; pop 2 -> remaining 2 enter, count=8.
- Overflow and clear: repeat rise on channel 0 while its bit is pending behind a full FIFO -> overflow=1, irq=1 next clock; overflow_clr=1 -> overflow=0.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Multi-channel input event controller: per-channel sync + debounce + edge
// detection, pending-request latching, round-robin arbitration into a
// first-word-fall-through event FIFO with interrupt and sticky overflow.

// Per-channel front end: two-flop synchroniser, debounce counter and
// edge request generation.
module edge_event_arbiter_chan #(
   parameter int   DEBOUNCE = 16,
   parameter logic IDLE     = 1'b0
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic ce,
   input  logic din,
   input  logic rise_en,
   input  logic fall_en,
   output logic level,
   output logic rise_req,
   output logic fall_req
);
   localparam int             CW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE - 1);

   logic          sync1, sync2;
   logic [CW-1:0] cnt;
   logic          accept;

   // New level is accepted on the ce tick that completes the hold window;
   // the edge request fires in that same clock.
   assign accept   = ce & (sync2 != level) & (cnt == LAST);
   assign rise_req = accept &  sync2 & rise_en;
   assign fall_req = accept & ~sync2 & fall_en;

   // Two-flop synchroniser for the raw asynchronous input.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= IDLE;
         sync2 <= IDLE;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   // Debounce: count ce ticks while the synchronised input differs from
   // the accepted level; any return to the accepted level restarts it.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         level <= IDLE;
         cnt   <= '0;
      end else if (sync2 == level) begin
         cnt <= '0;
      end else if (ce) begin
         if (cnt == LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module edge_event_arbiter #(
   parameter int                  CHANNELS   = 8,
   parameter int                  DEBOUNCE   = 16,
   parameter int                  FIFO_DEPTH = 8,
   parameter logic [CHANNELS-1:0] IDLE_LEVEL = '0,
   localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int AW  = $clog2(FIFO_DEPTH)
) (
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic                ce,
   input  logic [CHANNELS-1:0] signal_in,
   input  logic [CHANNELS-1:0] rise_en,
   input  logic [CHANNELS-1:0] fall_en,
   output logic [CHANNELS-1:0] level_out,
   output logic                evt_valid,
   output logic [CHW-1:0]      evt_chan,
   output logic                evt_dir,
   input  logic                evt_ready,
   output logic [AW:0]         evt_count,
   output logic                overflow,
   input  logic                overflow_clr,
   output logic                irq
);
   localparam int NREQ = 2 * CHANNELS;
   localparam int PW   = $clog2(NREQ);

   logic [CHANNELS-1:0] rise_req, fall_req;
   logic [NREQ-1:0]     req_vec;
   logic [NREQ-1:0]     pend;
   logic [PW-1:0]       ptr;

   logic                gnt_vld;
   logic [PW-1:0]       gnt_idx;
   logic [PW:0]         srch;
   logic [NREQ-1:0]     gnt_mask;
   logic                coalesce;

   logic [CHW-1:0]      mem_chan [FIFO_DEPTH];
   logic                mem_dir  [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic                fifo_full, push, pop;

   // Per-channel front ends; requests are interleaved rise/fall per channel.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      edge_event_arbiter_chan #(
         .DEBOUNCE (DEBOUNCE),
         .IDLE     (IDLE_LEVEL[i])
      ) u_chan (
         .clk_sys  (clk_sys),
         .reset_n  (reset_n),
         .ce       (ce),
         .din      (signal_in[i]),
         .rise_en  (rise_en[i]),
         .fall_en  (fall_en[i]),
         .level    (level_out[i]),
         .rise_req (rise_req[i]),
         .fall_req (fall_req[i])
      );
      assign req_vec[2*i]   = rise_req[i];
      assign req_vec[2*i+1] = fall_req[i];
   end

   assign fifo_full = (evt_count == (AW+1)'(FIFO_DEPTH));
   assign evt_valid = (evt_count != '0);
   assign evt_chan  = mem_chan[rd_ptr];
   assign evt_dir   = mem_dir[rd_ptr];
   assign push      = gnt_vld;
   assign pop       = evt_valid & evt_ready;

   // Cyclic first-set search of the pending bits starting at ptr; no grant
   // while the FIFO is full so nothing is ever dropped at the FIFO.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      srch    = '0;
      if (!fifo_full) begin
         for (int k = 0; k < NREQ; k++) begin
            srch = {1'b0, ptr} + (PW+1)'(k);
            if (srch >= (PW+1)'(NREQ))
               srch = srch - (PW+1)'(NREQ);
            if (!gnt_vld && pend[srch[PW-1:0]]) begin
               gnt_vld = 1'b1;
               gnt_idx = srch[PW-1:0];
            end
         end
      end
   end

   assign gnt_mask = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
   // A request landing on a bit that stays pending is merged and lost.
   assign coalesce = |(req_vec & pend & ~gnt_mask);

   // Pending bits and round-robin pointer.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         pend <= '0;
         ptr  <= '0;
      end else begin
         pend <= (pend & ~gnt_mask) | req_vec;
         if (gnt_vld)
            ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Event FIFO storage and pointers; pointers wrap naturally.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < FIFO_DEPTH; j++) begin
            mem_chan[j] <= '0;
            mem_dir[j]  <= 1'b0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem_chan[wr_ptr] <= CHW'(gnt_idx >> 1);
            mem_dir[wr_ptr]  <= ~gnt_idx[0];
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Occupancy: simultaneous push and pop leave it unchanged.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         evt_count <= '0;
      else if (push && !pop)
         evt_count <= evt_count + 1'b1;
      else if (pop && !push)
         evt_count <= evt_count - 1'b1;
   end

   // Sticky overflow; a new loss in the clearing clock keeps it set.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         overflow <= 1'b0;
      else if (coalesce)
         overflow <= 1'b1;
      else if (overflow_clr)
         overflow <= 1'b0;
   end

   // Registered interrupt.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         irq <= 1'b0;
      else
         irq <= evt_valid | overflow;
   end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomised + directed bench for edge_event_arbiter with a queue-based
// reference model stepped on every rising clock.
module tb_edge_event_arbiter;
   localparam int CH = 8, DB = 4, DEPTH = 8, NREQ = 16;
   localparam logic [7:0] IDLE = 8'h01;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          ce = 1'b1;
   logic [CH-1:0] signal_in = IDLE;
   logic [CH-1:0] rise_en = '0, fall_en = '0;
   logic [CH-1:0] level_out;
   logic          evt_valid, evt_dir, evt_ready = 1'b0;
   logic [2:0]    evt_chan;
   logic [3:0]    evt_count;
   logic          overflow, overflow_clr = 1'b0, irq;

   int errors = 0, checks = 0;

   // reference model state
   logic [CH-1:0]   m_s1, m_s2, m_lvl;
   int              m_hold [CH];
   logic [NREQ-1:0] m_pend;
   int              m_ptr;
   int              q_chan[$];
   bit              q_dir[$];
   bit              m_ovf, m_irq;

   edge_event_arbiter #(
      .CHANNELS(CH), .DEBOUNCE(DB), .FIFO_DEPTH(DEPTH), .IDLE_LEVEL(IDLE)
   ) dut (
      .clk_sys(clk), .reset_n(reset_n), .ce(ce), .signal_in(signal_in),
      .rise_en(rise_en), .fall_en(fall_en), .level_out(level_out),
      .evt_valid(evt_valid), .evt_chan(evt_chan), .evt_dir(evt_dir),
      .evt_ready(evt_ready), .evt_count(evt_count), .overflow(overflow),
      .overflow_clr(overflow_clr), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = IDLE; m_s2 = IDLE; m_lvl = IDLE;
      for (int c = 0; c < CH; c++) m_hold[c] = 0;
      m_pend = '0; m_ptr = 0;
      q_chan.delete(); q_dir.delete();
      m_ovf = 0; m_irq = 0;
   endtask

   // One clock of the specification's rules, from the pre-edge state.
   task automatic model_step();
      logic [NREQ-1:0] req;
      int  g, b;
      bit  nirq, dopop, coal;
      if (!reset_n) begin model_reset(); return; end
      nirq  = (q_chan.size() != 0) || m_ovf;
      dopop = (q_chan.size() != 0) && evt_ready;
      g = -1;
      if (q_chan.size() < DEPTH)
         for (int k = 0; k < NREQ; k++) begin
            b = (m_ptr + k) % NREQ;
            if (g < 0 && m_pend[b]) g = b;
         end
      req = '0;
      for (int c = 0; c < CH; c++) begin
         if (m_s2[c] == m_lvl[c]) m_hold[c] = 0;
         else if (ce) begin
            m_hold[c]++;
            if (m_hold[c] == DB) begin
               m_lvl[c] = m_s2[c];
               m_hold[c] = 0;
               if (m_lvl[c] && rise_en[c]) req[2*c] = 1'b1;
               if (!m_lvl[c] && fall_en[c]) req[2*c+1] = 1'b1;
            end
         end
      end
      coal = 0;
      for (int k = 0; k < NREQ; k++)
         if (req[k] && m_pend[k] && k != g) coal = 1;
      if (g >= 0) m_pend[g] = 1'b0;
      m_pend |= req;
      if (coal) m_ovf = 1; else if (overflow_clr) m_ovf = 0;
      if (dopop) begin void'(q_chan.pop_front()); void'(q_dir.pop_front()); end
      if (g >= 0) begin
         q_chan.push_back(g / 2);
         q_dir.push_back(g % 2 == 0);
         m_ptr = (g + 1) % NREQ;
      end
      m_s2 = m_s1; m_s1 = signal_in;
      m_irq = nirq;
   endtask

   task automatic check_all();
      chk("level_out", 32'(level_out), 32'(m_lvl));
      chk("evt_valid", 32'(evt_valid), 32'(q_chan.size() != 0));
      chk("evt_count", 32'(evt_count), 32'(q_chan.size()));
      if (q_chan.size() != 0) begin
         chk("evt_chan", 32'(evt_chan), 32'(q_chan[0]));
         chk("evt_dir", 32'(evt_dir), 32'(q_dir[0]));
      end
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("irq", 32'(irq), 32'(m_irq));
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         check_all();
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all();
      tick(2);
      reset_n = 1'b1;
   endtask

   task automatic pop_expect(input string tag, input int ch, input bit dir);
      chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
      chk({tag, "_chan"}, 32'(evt_chan), 32'(ch));
      chk({tag, "_dir"}, 32'(evt_dir), 32'(dir));
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      // reset state
      signal_in = IDLE;
      do_reset();
      chk("rst_level", 32'(level_out), 32'h01);
      chk("rst_valid", 32'(evt_valid), 32'd0);
      chk("rst_count", 32'(evt_count), 32'd0);
      chk("rst_chan", 32'(evt_chan), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      tick(10);
      chk("idle_no_evt", 32'(evt_count), 32'd0);

      // single edge latency: DB+3 = 7 edges
      rise_en = 8'hFF; fall_en = 8'hFF; ce = 1'b1;
      signal_in = 8'h09;
      tick(6);
      chk("lat_before", 32'(evt_valid), 32'd0);
      tick();
      chk("lat_valid", 32'(evt_valid), 32'd1);
      chk("lat_chan", 32'(evt_chan), 32'd3);
      chk("lat_dir", 32'(evt_dir), 32'd1);
      chk("lat_count", 32'(evt_count), 32'd1);
      evt_ready = 1'b1; tick(); evt_ready = 1'b0;
      chk("pop_count", 32'(evt_count), 32'd0);

      // glitch of 3 ticks is rejected
      signal_in[2] = 1'b1; tick(3);
      signal_in[2] = 1'b0; tick(20);
      chk("glitch", 32'(evt_count), 32'd0);
      // slow ce: held level gives one event
      signal_in[2] = 1'b1;
      for (int i = 0; i < 40; i++) begin ce = (i % 4 == 0); tick(); end
      ce = 1'b1;
      chk("slow_ce", 32'(evt_count), 32'd1);
      pop_expect("slow", 2, 1'b1);

      // round robin from ptr 0
      signal_in = IDLE;
      do_reset();
      signal_in = 8'h63; tick(12);
      chk("rr_count", 32'(evt_count), 32'd3);
      pop_expect("rr0", 1, 1'b1);
      pop_expect("rr1", 5, 1'b1);
      pop_expect("rr2", 6, 1'b1);
      signal_in = 8'hC1; tick(12);
      pop_expect("rr3", 7, 1'b1);
      pop_expect("rr4", 1, 1'b0);
      pop_expect("rr5", 5, 1'b0);

      // full FIFO, then overflow on ch0
      signal_in = IDLE;
      fall_en = 8'hFE;
      do_reset();
      signal_in = 8'hFF; tick(10);
      signal_in = 8'hF1; tick(10);
      chk("full_count", 32'(evt_count), 32'd8);
      chk("full_ovf", 32'(overflow), 32'd0);
      evt_ready = 1'b1; tick(2); evt_ready = 1'b0;
      tick(4);
      chk("refill_count", 32'(evt_count), 32'd8);
      signal_in = 8'hF0; tick(8);
      signal_in = 8'hF1; tick(8);
      chk("pend_no_ovf", 32'(overflow), 32'd0);
      signal_in = 8'hF0; tick(8);
      signal_in = 8'hF1; tick(8);
      chk("ovf_set", 32'(overflow), 32'd1);
      tick();
      chk("ovf_irq", 32'(irq), 32'd1);
      overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'd0);

      // randomised traffic with a mid-run reset
      fall_en = 8'hFF;
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 11) == 0) signal_in[c] = ~signal_in[c];
         ce           = ($urandom_range(0, 3) != 0);
         evt_ready    = (i % 400 < 150) ? 1'b0 : 1'($urandom_range(0, 1));
         overflow_clr = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 99) == 0) rise_en = 8'($urandom);
         if ($urandom_range(0, 99) == 0) fall_en = 8'($urandom);
         if (i == 1500) do_reset();
         else tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
